// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and types; the return stack uses these for its defaults.
package cpu_pkg;

  localparam int unsigned PC_W     = 10;
  localparam int unsigned RS_DEPTH = 8;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    RS_HOLD = 2'b00,
    RS_POP  = 2'b01,
    RS_PUSH = 2'b10,
    RS_REPL = 2'b11
  } rs_op_e;

endpackage

// File: rtl/return_stack_if.sv
// Push/pop request and status bundle between the decoder/PC and the return stack.
interface return_stack_if #(
  parameter int unsigned DEPTH = cpu_pkg::RS_DEPTH,
  parameter int unsigned AW    = cpu_pkg::PC_W
);

  logic                       push;
  logic                       pop;
  logic [AW-1:0]              push_addr;
  logic                       err_clr;
  logic [AW-1:0]              rl;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       ovf;
  logic                       unf;

  modport master (
    output push, pop, push_addr, err_clr,
    input  rl, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, push_addr, err_clr,
    output rl, count, empty, full, ovf, unf
  );

endinterface

// File: rtl/return_stack.sv
// Circular LIFO of return addresses; top of stack is shown on rl so the PC can
// load it on the same edge that pops it.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH,
  parameter int unsigned AW    = PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  return_stack_if.slave     bus
);

  localparam int unsigned SPW = $clog2(DEPTH);
  localparam int unsigned CW  = SPW + 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           empty, full;
  logic [SPW-1:0] top_idx;
  rs_op_e         op;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign top_idx = sp_q - SP_ONE;
  assign op      = rs_op_e'({bus.push, bus.pop});

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = bus.err_clr ? 1'b0 : ovf_q;
    unf_d = bus.err_clr ? 1'b0 : unf_q;

    if (start) begin
      sp_d  = '0;
      cnt_d = '0;
    end else begin
      unique case (op)
        RS_PUSH: begin
          mem_d[sp_q] = bus.push_addr;
          sp_d        = sp_q + SP_ONE;
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CNT_ONE;
        end
        RS_POP: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        RS_REPL: begin
          // Empty stack degrades to a plain push, still flagged as underflow.
          if (empty) begin
            mem_d[sp_q] = bus.push_addr;
            sp_d        = sp_q + SP_ONE;
            cnt_d       = cnt_q + CNT_ONE;
            unf_d       = 1'b1;
          end else begin
            mem_d[top_idx] = bus.push_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    bus.rl    = empty ? '0 : mem_q[top_idx];
    bus.count = cnt_q;
    bus.empty = empty;
    bus.full  = full;
    bus.ovf   = ovf_q;
    bus.unf   = unf_q;
  end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: vector table plus overflow/start sequences.
module tb_return_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 10;

  logic clk;
  logic rst_n;
  logic start;

  return_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [AW-1:0] addr;
    logic [AW-1:0] rl;
    int unsigned   cnt;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t vecs [$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic vec_t mk(logic pu, logic po, logic ec, logic [AW-1:0] a,
                              logic [AW-1:0] r, int unsigned c,
                              logic e, logic f, logic o, logic u);
    vec_t v;
    v.push = pu; v.pop = po; v.err_clr = ec; v.addr = a;
    v.rl = r; v.cnt = c; v.empty = e; v.full = f; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic check_state(input string name, input logic [AW-1:0] rl,
                             input int unsigned cnt, input logic e, input logic f,
                             input logic o, input logic u);
    n_total++;
    if (bus.rl === rl && bus.count === 4'(cnt) && bus.empty === e &&
        bus.full === f && bus.ovf === o && bus.unf === u) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rl=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want rl=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               name, bus.rl, bus.count, bus.empty, bus.full, bus.ovf, bus.unf,
               rl, cnt, e, f, o, u);
    end
  endtask

  task automatic check_rl(input string name, input logic [AW-1:0] rl);
    n_total++;
    if (bus.rl === rl) n_pass++;
    else $display("FAIL %s: got rl=%h want rl=%h", name, bus.rl, rl);
  endtask

  task automatic drive(input logic pu, input logic po, input logic ec,
                       input logic st, input logic [AW-1:0] a);
    @(negedge clk);
    bus.push = pu; bus.pop = po; bus.err_clr = ec; start = st; bus.push_addr = a;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0; bus.push_addr = '0;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    check_state("reset", 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    //          push pop clr addr    rl      cnt em fu ov un
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10'h012, 10'h012, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10'h234, 10'h234, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10'h3FF, 10'h3FF, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h234, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h012, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 10'h000, 10'h000, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 10'h000, 10'h000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10'h100, 10'h100, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10'h200, 10'h200, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 10'h2AA, 10'h2AA, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h100, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 10'h055, 10'h055, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 10'h000, 10'h055, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].err_clr, 1'b0, vecs[i].addr);
      settle();
      check_state($sformatf("vec%0d", i), vecs[i].rl, vecs[i].cnt,
                  vecs[i].empty, vecs[i].full, vecs[i].ovf, vecs[i].unf);
    end

    // Overflow: nine pushes into eight slots, then drain with rl checked pre-edge.
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 0, 10'(k));
      settle();
      if (k == 8) check_state("ovf_full8", 10'h008, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_state("ovf_push9", 10'h009, 8, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 9; k >= 2; k--) begin
      drive(0, 1, 0, 0, 10'h000);
      #1;
      check_rl($sformatf("ovf_pop_rl%0d", k), 10'(k));
      settle();
    end
    check_state("ovf_drained", 10'h000, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(0, 1, 0, 0, 10'h000);
    settle();
    check_state("ovf_lost_oldest", 10'h000, 0, 1'b1, 1'b0, 1'b1, 1'b1);

    // start mid-sequence with a concurrent push; sticky flags survive.
    drive(0, 0, 1, 0, 10'h000);
    settle();
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 0, 0, 10'h040 + 10'(k));
      settle();
    end
    check_state("start_pre", 10'h048, 8, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 0, 0, 1, 10'h3AB);
    settle();
    check_state("start_clear", 10'h000, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1, 0, 0, 0, 10'h077);
    settle();
    check_state("start_after", 10'h077, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset with a concurrent push clears everything including flags.
    drive(1, 0, 0, 0, 10'h111);
    rst_n = 1'b0;
    settle();
    @(negedge clk);
    rst_n = 1'b1;
    bus.push = 1'b0;
    #1;
    check_state("reset_mid", 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
